// File: rtl/instruction_decode_stage_if.sv
// -----------------------------------------------------------------------------
// instruction_decode_stage_if
// Purpose : Bundles the handshake and bus signals of instruction_decode_stage.
//           The upstream/downstream driver uses the master modport and the
//           decode stage uses the slave modport.
// Signals : flush, in_valid/in_ready, instruction, pc    (fetch side)
//           out_valid/out_ready, decoded fields, immediates, itype,
//           pc_plus4, branch_target, jump_target, decoded_count (consumer side)
//           illegal (present only when ID_ILLEGAL_TRAP_EN is defined)
// Macro   : ID_ILLEGAL_TRAP_EN adds the registered `illegal` flag.
// -----------------------------------------------------------------------------
interface instruction_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction;
  logic [PC_W-1:0]   pc;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [XLEN-1:0]   imm_sext;
  logic [XLEN-1:0]   imm_zext;
  logic [1:0]        itype;
  logic [PC_W-1:0]   pc_plus4;
  logic [PC_W-1:0]   branch_target;
  logic [PC_W-1:0]   jump_target;
  logic [CNT_W-1:0]  decoded_count;
`ifdef ID_ILLEGAL_TRAP_EN
  logic              illegal;
`endif

  modport master (
    output flush, in_valid, instruction, pc, out_ready,
`ifdef ID_ILLEGAL_TRAP_EN
    input  illegal,
`endif
    input  in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
           imm_sext, imm_zext, itype, pc_plus4, branch_target, jump_target,
           decoded_count
  );

  modport slave (
    input  flush, in_valid, instruction, pc, out_ready,
`ifdef ID_ILLEGAL_TRAP_EN
    output illegal,
`endif
    output in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
           imm_sext, imm_zext, itype, pc_plus4, branch_target, jump_target,
           decoded_count
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// -----------------------------------------------------------------------------
// instruction_decode_stage
// Purpose : Registered MIPS decode stage with valid/ready flow control. The
//           incoming {instruction, pc} is decoded combinationally and the
//           resulting bundle is registered in a main register backed by a
//           one-entry skid register, so back-pressure never stalls a full-rate
//           stream by more than the downstream stall itself.
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous reset, active low
//           bus    - instruction_decode_stage_if.slave (handshakes, decoded
//                    fields, immediates, PC arithmetic, decoded_count)
// Macro   : ID_ILLEGAL_TRAP_EN - when defined, bus.illegal flags encodings
//           outside the supported opcode/funct sets; it travels with the bundle.
// -----------------------------------------------------------------------------
module instruction_decode_stage #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  instruction_decode_stage_if.slave    bus
);

`ifdef ID_ILLEGAL_TRAP_EN
  localparam int ILL_W = 1;
`else
  localparam int ILL_W = 0;
`endif
  // opcode+rs+rt+rd+shamt+funct, two immediates, itype, three PC values
  localparam int FIELD_W = 6 + 5 * 4 + 6 + 2 * XLEN + 2 + 3 * PC_W;
  localparam int BW      = FIELD_W + ILL_W;

  // Encoding chosen so bit0 = out_valid and bit1 = skid_valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     main_q, main_d;
  logic [BW-1:0]     skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              out_valid, skid_valid, accept, deliver;
  logic [BW-1:0]     dec_bundle;
  logic [5:0]        dec_op;
  logic [1:0]        dec_itype;
  logic [PC_W-1:0]   dec_pc4, dec_br, dec_jt;

`ifdef ID_ILLEGAL_TRAP_EN
  function automatic logic is_illegal(input logic [5:0] op, input logic [5:0] fn);
    logic ill;
    ill = 1'b1;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: ill = 1'b0;
          default: ill = 1'b1;
        endcase
      end
      6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: ill = 1'b0;
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction
`endif

  assign out_valid = state_q[0];
  assign skid_valid = state_q[1];
  assign bus.in_ready  = !skid_valid;
  assign bus.out_valid = out_valid;
  assign accept  = bus.in_valid && !skid_valid && !bus.flush;
  assign deliver = out_valid && bus.out_ready;

  // Combinational decode of the presented word.
  always_comb begin
    dec_op    = bus.instruction[31:26];
    dec_itype = (dec_op == 6'h00) ? 2'd0 :
                ((dec_op == 6'h02) || (dec_op == 6'h03)) ? 2'd2 : 2'd1;
    dec_pc4   = bus.pc + PC_W'(4);
    // Word offset sign-extended straight to PC_W, so any XLEN>PC_W case
    // naturally uses only the low PC_W bits.
    dec_br    = dec_pc4 + PC_W'($signed({bus.instruction[15:0], 2'b00}));
    // Keep pc_plus4 bits above 27 and splice in the 28-bit jump field;
    // a mask avoids a zero-width slice when PC_W is exactly 28.
    dec_jt    = (dec_pc4 & ({PC_W{1'b1}} << 28)) |
                PC_W'({bus.instruction[25:0], 2'b00});
    dec_bundle = '0;
    dec_bundle[BW-1 -: FIELD_W] = {
      dec_op,
      bus.instruction[25:21],
      bus.instruction[20:16],
      bus.instruction[15:11],
      bus.instruction[10:6],
      bus.instruction[5:0],
      XLEN'($signed(bus.instruction[15:0])),
      XLEN'(bus.instruction[15:0]),
      dec_itype,
      dec_pc4,
      dec_br,
      dec_jt
    };
`ifdef ID_ILLEGAL_TRAP_EN
    dec_bundle[0] = is_illegal(dec_op, bus.instruction[5:0]);
`endif
  end

  // Skid-buffer control; flush overrides everything but the count.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q + CNT_W'(deliver);
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = dec_bundle;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && deliver) begin
            main_d = dec_bundle;
          end else if (accept) begin
            skid_d  = dec_bundle;
            state_d = ST_FULL;
          end else if (deliver) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (deliver) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct,
          bus.imm_sext, bus.imm_zext, bus.itype,
          bus.pc_plus4, bus.branch_target, bus.jump_target} = main_q[BW-1 -: FIELD_W];
`ifdef ID_ILLEGAL_TRAP_EN
  assign bus.illegal = main_q[0];
`endif
  assign bus.decoded_count = cnt_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_instruction_decode_stage
// Scoreboard bench: each accepted vector pushes its hand-computed expected
// bundle; a negedge monitor pops and compares on every delivery.
// CNT_W is set to 3 so counter wrap is reachable in a short run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_decode_stage;

  localparam int XLEN = 32;
  localparam int PC_W = 32;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [31:0] sext;
    logic [31:0] zext;
    logic [1:0]  it;
    logic [31:0] pc4;
    logic [31:0] br;
    logic [31:0] jt;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs [7];
  vec_t sb [$];

  instruction_decode_stage_if #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  instruction_decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Monitor: one line per delivered bundle.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      logic [193:0] act, exp_b;
      vec_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_bundle opcode=%h pc_plus4=%h (no bundle expected)",
                 bus.opcode, bus.pc_plus4);
      end else begin
        e = sb.pop_front();
        act = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct, bus.imm_sext,
               bus.imm_zext, bus.itype, bus.pc_plus4, bus.branch_target, bus.jump_target};
        exp_b = {e.op, e.rs, e.rt, e.rd, e.sh, e.fn, e.sext, e.zext, e.it, e.pc4, e.br, e.jt};
        if (act !== exp_b) begin
          failures++;
          $display("FAIL bundle instr=%h got=%h expected=%h", e.instr, act, exp_b);
        end else begin
          $display("txn instr=%h pc=%h itype=%0d br=%h jt=%h ok", e.instr, e.pc,
                   bus.itype, bus.branch_target, bus.jump_target);
        end
`ifdef ID_ILLEGAL_TRAP_EN
        checks++;
        if (bus.illegal !== e.ill) begin
          failures++;
          $display("FAIL illegal instr=%h got=%b expected=%b", e.instr, bus.illegal, e.ill);
        end
`endif
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp_v);
    end
  endtask

  // Present a vector until accepted; expected bundle is queued on acceptance.
  task automatic send(input int idx);
    int n;
    n = 0;
    bus.instruction = vecs[idx].instr;
    bus.pc          = vecs[idx].pc;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout vec=%0d got=in_ready_low expected=accept", idx);
    end else begin
      sb.push_back(vecs[idx]);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d pending expected=0", sb.size());
    end
  endtask

  initial begin
    //          instr         pc            op     rs     rt     rd     sh     fn     sext          zext          it    pc4           br            jt            ill
    vecs[0] = '{32'h8C48FFFC, 32'h00400000, 6'h23, 5'd2,  5'd8,  5'd31, 5'd31, 6'h3C, 32'hFFFFFFFC, 32'h0000FFFC, 2'd1, 32'h00400004, 32'h003FFFF4, 32'h0123FFF0, 1'b0};
    vecs[1] = '{32'h08100003, 32'h10000000, 6'h02, 5'd0,  5'd16, 5'd0,  5'd0,  6'h03, 32'h00000003, 32'h00000003, 2'd2, 32'h10000004, 32'h10000010, 32'h1040000C, 1'b0};
    vecs[2] = '{32'h014B4820, 32'h00000100, 6'h00, 5'd10, 5'd11, 5'd9,  5'd0,  6'h20, 32'h00004820, 32'h00004820, 2'd0, 32'h00000104, 32'h00012184, 32'h052D2080, 1'b0};
    vecs[3] = '{32'h1109FFFF, 32'h80000000, 6'h04, 5'd8,  5'd9,  5'd31, 5'd31, 6'h3F, 32'hFFFFFFFF, 32'h0000FFFF, 2'd1, 32'h80000004, 32'h80000000, 32'h8427FFFC, 1'b0};
    vecs[4] = '{32'h0C000001, 32'hFFFFFFFC, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h01, 32'h00000001, 32'h00000001, 2'd2, 32'h00000000, 32'h00000004, 32'h00000004, 1'b0};
    vecs[5] = '{32'h34218000, 32'h00001000, 6'h0D, 5'd1,  5'd1,  5'd16, 5'd0,  6'h00, 32'hFFFF8000, 32'h00008000, 2'd1, 32'h00001004, 32'hFFFE1004, 32'h00860000, 1'b0};
    vecs[6] = '{32'hFC000000, 32'h00000200, 6'h3F, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 32'h00000000, 32'h00000000, 2'd1, 32'h00000204, 32'h00000204, 32'h00000000, 1'b1};

    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.instruction = '0;
    bus.pc = '0;
    #3;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_count", 64'(bus.decoded_count), 64'd0);
    chk("reset_imm_sext", 64'(bus.imm_sext), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-rate stream.
    bus.out_ready = 1'b1;
    send(0);
    send(1);
    send(2);
    drain();
    chk("count_after_stream", 64'(bus.decoded_count), 64'd3);

    // Back-pressure: second accept fills the skid and drops in_ready.
    bus.out_ready = 1'b0;
    send(3);
    chk("bp_ready_after_1st", 64'(bus.in_ready), 64'd1);
    send(4);
    chk("bp_ready_after_2nd", 64'(bus.in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_hold_opcode", 64'(bus.opcode), 64'(vecs[3].op));
    bus.out_ready = 1'b1;
    send(5);
    drain();
    chk("count_after_bp", 64'(bus.decoded_count), 64'd6);

    // Flush from FULL with a word presented in the same cycle.
    bus.out_ready = 1'b0;
    send(6);
    send(0);
    chk("flush_pre_full", 64'(bus.in_ready), 64'd0);
    bus.instruction = vecs[1].instr;
    bus.pc = vecs[1].pc;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_count", 64'(bus.decoded_count), 64'd6);

    // Recovery after flush, including the illegal-encoding vector.
    bus.out_ready = 1'b1;
    send(6);
    drain();
    chk("count_after_flush", 64'(bus.decoded_count), 64'd7);

    // Asynchronous reset while FULL.
    bus.out_ready = 1'b0;
    send(2);
    send(3);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("rst_full_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_full_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_full_count", 64'(bus.decoded_count), 64'd0);
    chk("rst_full_opcode", 64'(bus.opcode), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Nine deliveries wrap the 3-bit counter to 1.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(i % 7);
    drain();
    chk("count_wrap", 64'(bus.decoded_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
